// File: rtl/fp_addsub_arbiter.sv
// fp_addsub_arbiter: round-robin sharing of one fp_adder among NUM_REQ requesters (FP_ARB_STATS_EN adds grant_cnt)
module fp_adder (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] s
);
  logic [31:0] x, y;
  logic [7:0] ex, ey, d;
  logic [26:0] mx, my, my_sh, ys, m;
  logic [27:0] sum;
  logic [9:0] e;
  logic [24:0] r;
  logic sub, lost, rnd;
  // Align the smaller magnitude, add or subtract, normalise, round to nearest even
  always_comb begin
    x = (b[30:0] > a[30:0]) ? b : a;
    y = (b[30:0] > a[30:0]) ? a : b;
    ex = (x[30:23] == 8'd0) ? 8'd1 : x[30:23];
    ey = (y[30:23] == 8'd0) ? 8'd1 : y[30:23];
    mx = {x[30:23] != 8'd0, x[22:0], 3'b0};
    my = {y[30:23] != 8'd0, y[22:0], 3'b0};
    d = ex - ey;
    my_sh = (d > 8'd26) ? 27'd0 : my >> d;
    lost = (d > 8'd26) ? |my : |(my & ~(27'h7FF_FFFF << d));
    ys = {my_sh[26:1], my_sh[0] | lost};
    sub = x[31] ^ y[31];
    sum = sub ? {1'b0, mx} - {1'b0, ys} : {1'b0, mx} + {1'b0, ys};
    e = {2'b0, ex} + {9'd0, sum[27]};
    m = sum[27] ? {sum[27:2], sum[1] | sum[0]} : sum[26:0];
    for (int i = 0; i < 26; i++) begin
      if (!m[26] && e > 10'd1) begin
        m = m << 1;
        e = e - 10'd1;
      end
    end
    rnd = m[2] & (m[1] | m[0] | m[3]);
    r = {1'b0, m[26:3]} + {24'd0, rnd};
    e = e + {9'd0, r[24]};
    r = r[24] ? r >> 1 : r;
    s = (e >= 10'd255) ? {x[31], 8'hFF, 23'd0} : {x[31], r[23] ? e[7:0] : 8'd0, r[22:0]};
    s = (sum == 28'd0) ? {sub ? 1'b0 : x[31], 31'd0} : s;
    s = (x[30:23] == 8'hFF) ? (((x[22:0] != 23'd0) || (y[30:23] == 8'hFF && sub)) ? 32'h7FC0_0000 : x) : s;
  end
endmodule

module fp_addsub_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [32*NUM_REQ-1:0]  req_a,
  input  logic [32*NUM_REQ-1:0]  req_b,
  input  logic [NUM_REQ-1:0]     req_sub,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [ID_W-1:0]        resp_id,
  output logic [31:0]            resp_s,
  output logic                   busy
`ifdef FP_ARB_STATS_EN
  ,output logic [16*NUM_REQ-1:0] grant_cnt
`endif
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;
  logic [1:0] state_q, state_d;
  logic [ID_W-1:0] rr_q, rr_d, id_q, id_d, resp_id_q, resp_id_d, win;
  logic [31:0] op_a_q, op_a_d, op_b_q, op_b_d, resp_s_q, resp_s_d, sum;
  logic resp_valid_q, resp_valid_d, found, acc;
  int j;
  fp_adder u_add (.a(op_a_q), .b(op_b_q), .s(sum));
  // Pick the first valid requester scanning upward from rr_q, wrapping at NUM_REQ
  always_comb begin
    win = '0;
    found = 1'b0;
    j = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      j = (int'(rr_q) + k) % NUM_REQ;
      if (req_valid[j]) begin
        win = ID_W'(j);
        found = 1'b1;
      end
    end
    acc = found & (state_q == IDLE | (state_q == RESP & resp_ready));
    req_ready = acc ? NUM_REQ'(1) << win : '0;
  end
  // Transaction FSM: latch operands on accept, register the sum, hold it until taken
  always_comb begin
    state_d = state_q;
    rr_d = rr_q;
    id_d = id_q;
    op_a_d = op_a_q;
    op_b_d = op_b_q;
    resp_s_d = resp_s_q;
    resp_id_d = resp_id_q;
    resp_valid_d = resp_valid_q;
    if (state_q == CALC) begin
      resp_s_d = sum;
      resp_id_d = id_q;
      resp_valid_d = 1'b1;
      state_d = RESP;
    end
    if (state_q == RESP && resp_ready) begin
      resp_valid_d = 1'b0;
      state_d = IDLE;
    end
    if (acc) begin
      op_a_d = req_a[32*win +: 32];
      op_b_d = req_b[32*win +: 32] ^ {req_sub[win], 31'b0};
      id_d = win;
      rr_d = (int'(win) == NUM_REQ - 1) ? '0 : win + 1'b1;
      state_d = CALC;
    end
  end
  // State registers with synchronous reset taking priority over any handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rr_q <= '0;
      id_q <= '0;
      op_a_q <= '0;
      op_b_q <= '0;
      resp_s_q <= '0;
      resp_id_q <= '0;
      resp_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q <= rr_d;
      id_q <= id_d;
      op_a_q <= op_a_d;
      op_b_q <= op_b_d;
      resp_s_q <= resp_s_d;
      resp_id_q <= resp_id_d;
      resp_valid_q <= resp_valid_d;
    end
  end
  assign resp_valid = resp_valid_q;
  assign resp_id = resp_id_q;
  assign resp_s = resp_s_q;
  assign busy = state_q != IDLE;
`ifdef FP_ARB_STATS_EN
  logic [NUM_REQ-1:0][15:0] cnt_q, cnt_d;
  // Per-requester accept counters, wrapping at 16 bits
  always_comb begin
    cnt_d = cnt_q;
    if (acc) cnt_d[win] = cnt_q[win] + 16'd1;
  end
  // Counter registers
  always_ff @(posedge clk) begin
    cnt_q <= rst ? '0 : cnt_d;
  end
  assign grant_cnt = cnt_q;
`endif
endmodule

// File: tb/tb_fp_addsub_arbiter.sv
// tb_fp_addsub_arbiter: directed scoreboard bench for fp_addsub_arbiter
module tb_fp_addsub_arbiter;
  localparam int N = 4;
  logic clk = 1'b0, rst = 1'b1, resp_ready = 1'b1;
  logic [N-1:0] req_valid = '0, req_sub = '0, req_ready;
  logic [32*N-1:0] req_a = '0, req_b = '0;
  logic resp_valid, busy;
  logic [1:0] resp_id;
  logic [31:0] resp_s;
  logic [33:0] q[$];
  logic [33:0] exp_e;
  int checks = 0, errors = 0, n_resp = 0;
`ifdef FP_ARB_STATS_EN
  logic [16*N-1:0] grant_cnt;
`endif
  fp_addsub_arbiter #(.NUM_REQ(N), .ID_W(2)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_sub(req_sub), .resp_valid(resp_valid),
    .resp_ready(resp_ready), .resp_id(resp_id), .resp_s(resp_s), .busy(busy)
`ifdef FP_ARB_STATS_EN
    , .grant_cnt(grant_cnt)
`endif
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic setop(input int i, input logic [31:0] a, input logic [31:0] b, input logic sub);
    req_a[32*i +: 32] = a;
    req_b[32*i +: 32] = b;
    req_sub[i] = sub;
  endtask
  task automatic issue(input int i, input logic [31:0] a, input logic [31:0] b, input logic sub, input logic [31:0] s);
    bit got = 0;
    setop(i, a, b, sub);
    req_valid[i] = 1'b1;
    q.push_back({2'(i), s});
    for (int t = 0; t < 20 && !got; t++) begin
      #1;
      if (req_ready[i]) got = 1;
      tick();
    end
    chk("accept", 64'(got), 64'd1);
    req_valid[i] = 1'b0;
  endtask
  task automatic drain();
    for (int t = 0; t < 20 && (q.size() != 0 || busy); t++) tick();
    chk("drain", 64'(q.size()), 64'd0);
  endtask
  // Scoreboard: every accepted response must match the oldest expected entry
  always @(negedge clk) begin
    if (!rst && resp_valid && resp_ready) begin
      n_resp++;
      if (q.size() == 0) chk("unexpected_resp", {30'd0, resp_id, resp_s}, 64'd0);
      else begin
        exp_e = q.pop_front();
        chk("resp_id", 64'(resp_id), 64'(exp_e[33:32]));
        chk("resp_s", 64'(resp_s), 64'(exp_e[31:0]));
      end
    end
  end
  initial begin
    tick();
    tick();
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_resp_id", 64'(resp_id), 64'd0);
    chk("rst_resp_s", 64'(resp_s), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    rst = 1'b0;
    tick();
    chk("idle_ready", 64'(req_ready), 64'd0);
    setop(0, 32'h3F80_0000, 32'h4000_0000, 1'b0);
    req_valid = 4'b0001;
    #1;
    chk("t1_ready", 64'(req_ready), 64'b0001);
    q.push_back({2'd0, 32'h4040_0000});
    tick();
    req_valid = '0;
    chk("t1_calc_ready", 64'(req_ready), 64'd0);
    chk("t1_calc_valid", 64'(resp_valid), 64'd0);
    chk("t1_busy", 64'(busy), 64'd1);
    tick();
    chk("t1_valid", 64'(resp_valid), 64'd1);
    chk("t1_s", 64'(resp_s), 64'h4040_0000);
    drain();
    issue(2, 32'h4040_0000, 32'h3F80_0000, 1'b1, 32'h4000_0000);
    drain();
    issue(2, 32'h3F80_0000, 32'h3F80_0000, 1'b1, 32'h0000_0000);
    drain();
    issue(1, 32'hBF80_0000, 32'h3F00_0000, 1'b0, 32'hBF00_0000);
    drain();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    setop(0, 32'h3F80_0000, 32'h4000_0000, 1'b0);
    setop(1, 32'h3FC0_0000, 32'h3E80_0000, 1'b0);
    setop(2, 32'h4040_0000, 32'h3F80_0000, 1'b1);
    setop(3, 32'hBF80_0000, 32'h3F00_0000, 1'b0);
    q.push_back({2'd0, 32'h4040_0000});
    q.push_back({2'd1, 32'h3FE0_0000});
    q.push_back({2'd2, 32'h4000_0000});
    q.push_back({2'd3, 32'hBF00_0000});
    q.push_back({2'd0, 32'h4040_0000});
    n_resp = 0;
    req_valid = 4'b1111;
    for (int t = 1; t <= 10; t++) begin
      tick();
      if (t == 9) req_valid = '0;
      chk("t3_cadence", 64'(resp_valid), 64'(t % 2 == 0));
    end
    drain();
    chk("t3_count", 64'(n_resp), 64'd5);
    resp_ready = 1'b0;
    issue(1, 32'h4000_0000, 32'h4000_0000, 1'b0, 32'h4080_0000);
    tick();
    setop(1, 32'h3F00_0000, 32'h3F00_0000, 1'b0);
    req_valid = 4'b0010;
    q.push_back({2'd1, 32'h3F80_0000});
    for (int t = 0; t < 5; t++) begin
      chk("t4_ready", 64'(req_ready), 64'd0);
      chk("t4_valid", 64'(resp_valid), 64'd1);
      chk("t4_hold", {30'd0, resp_id, resp_s}, {30'd0, 2'd1, 32'h4080_0000});
      tick();
    end
    resp_ready = 1'b1;
    #1;
    chk("t4_release", 64'(req_ready), 64'b0010);
    tick();
    req_valid = '0;
    chk("t4_calc", 64'(busy), 64'd1);
    drain();
    issue(2, 32'h3F80_0000, 32'h3F80_0000, 1'b0, 32'h4000_0000);
    void'(q.pop_back());
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_valid", 64'(resp_valid), 64'd0);
    chk("t5_busy", 64'(busy), 64'd0);
    req_valid = 4'b1111;
    #1;
    chk("t5_rrptr", 64'(req_ready), 64'b0001);
    req_valid = '0;
    for (int t = 0; t < 4; t++) tick();
    chk("t5_no_stale", 64'(resp_valid), 64'd0);
`ifdef FP_ARB_STATS_EN
    for (int t = 0; t < 3; t++) begin
      issue(3, 32'h3F80_0000, 32'h3F80_0000, 1'b0, 32'h4000_0000);
      drain();
    end
    chk("t6_cnt3", 64'(grant_cnt[63:48]), 64'd3);
    dut.cnt_q[3] = 16'hFFFF;
    tick();
    issue(3, 32'h3F80_0000, 32'h3F80_0000, 1'b0, 32'h4000_0000);
    drain();
    chk("t6_wrap", 64'(grant_cnt[63:48]), 64'd0);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fp_addsub_arbiter.md
Name: fp_addsub_arbiter

Overview:
Shares one combinational fp_adder (ports a, b, s; IEEE-754 single precision) between NUM_REQ requesters.
- Each requester submits an add or subtract over a valid/ready handshake.
- Grants are round-robin. Operands are registered into the adder and the sum is registered out.
- One result is returned per transaction, tagged with the requester ID.
- Sits between the issuing units and the shared FP datapath; the only instance of fp_adder in its subtree.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..8.
- ID_W, 2, width of resp_id; must satisfy 2^ID_W >= NUM_REQ.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero.
- req_a  in  32*NUM_REQ  operand A; requester i occupies bits [32i+31:32i].
- req_b  in  32*NUM_REQ  operand B; same packing as req_a.
- req_sub  in  NUM_REQ  1 = compute a-b, 0 = compute a+b.
- resp_valid  out  1  result available.
- resp_ready  in  1  consumer accepts result.
- resp_id  out  ID_W  index of requester owning the result.
- resp_s  out  32  result word.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- FSM states: IDLE, CALC, RESP. Reset value is IDLE.
- Reset values: resp_valid=0, resp_id=0, resp_s=0, req_ready=0, rr_ptr=0. Operand registers are cleared to 0.
- Arbitration: rr_ptr (ID_W bits) is the highest-priority index. Scan rr_ptr, rr_ptr+1, … mod NUM_REQ; the first asserted req_valid wins.
- IDLE:
  - req_ready[g] is asserted combinationally for the winner g only, and only when at least one req_valid is high.
  - Handshake (req_valid[g] & req_ready[g]) latches op_a <= req_a[g] and op_b <= req_b[g] ^ {req_sub[g], 31'b0}. It also latches id <= g, sets rr_ptr <= (g+1) mod NUM_REQ, and moves to CALC.
- CALC:
  - The adder sees a=op_a, b=op_b.
  - On the clock edge: resp_s <= adder s, resp_id <= id, resp_valid <= 1, state -> RESP.
- RESP:
  - resp_valid, resp_s and resp_id are held stable until resp_ready=1.
  - On the handshake edge: resp_valid <= 0.
  - Back-to-back: if any req_valid is high in the same cycle, the winner's req_ready is asserted in RESP only while resp_ready=1. A new transaction is then latched and the FSM goes directly to CALC. Otherwise it goes to IDLE.
- Latency: accept at edge N; resp_valid is high after edge N+1. Peak throughput is one operation per 2 cycles with resp_ready held high.
- Requesters may drop req_valid without a handshake; no state change results.
- req_ready is never asserted in CALC.
- The result is bit-exact fp_adder output; no rounding or flags are added here.
- Simultaneous requests: exactly one grant per accept. rr_ptr guarantees each requester holding valid is served within NUM_REQ transactions.
- rst mid-operation (CALC or RESP): the in-flight result is discarded, all outputs return to reset values, and state goes to IDLE the next cycle. rst has priority over every handshake.
- A requester index >= NUM_REQ is never granted; rr_ptr wraps from NUM_REQ-1 to 0.

Optional Feature:
- FP_ARB_STATS_EN defined: adds output grant_cnt (16*NUM_REQ bits).
  - One 16-bit counter per requester, incremented on that requester's accept handshake.
  - Counters wrap 0xFFFF -> 0x0000 and are cleared by rst.
- Undefined: port and counters absent; behaviour otherwise identical.

Test Plan:
1. Reset, then req0: a=3F800000, b=40000000, sub=0 -> req_ready[0] same cycle; resp_valid two edges later with resp_s=40400000, resp_id=0.
2. req2 sub=1: a=40400000, b=3F800000 -> resp_s=40000000, resp_id=2. Also a=b=3F800000 with sub=1 -> resp_s=00000000.
3. After reset, req_valid=1111 held with resp_ready=1 -> resp_id sequence 0,1,2,3,0, one result every 2 cycles.
4. resp_ready=0 for 5 cycles while req1 pending -> resp_s/resp_id stable and req_ready=0 throughout. Releasing resp_ready -> req1 accepted that cycle.
5. Assert rst during CALC -> next cycle resp_valid=0, busy=0, rr_ptr=0; no stale response appears.
6. FP_ARB_STATS_EN: 3 accepts from req3 -> grant_cnt[63:48]=3. Preload 0xFFFF plus one accept -> wraps to 0.
